secret_mac: RTL and testbench

- Responder side of the protected-lib example: the "secret" core a top-level harness drives with operands `a`/`b` and samples result `x` from.
- Accepts one operand pair per valid/ready handshake and multiplies it iteratively with a shift-add engine.
- Accumulates the low WIDTH bits of each product into a running sum, presented on `x`.
- Built as a plain Verilog module, intended to be wrapped by `--protect-lib`.

---
 rtl/secret_mac.sv | 90 +++++++++
 tb/tb_secret_mac.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/secret_mac.sv
// Iterative shift-add multiplier with a running accumulator of product low bits.
// One operand pair per valid/ready handshake; fixed WIDTH-cycle multiply latency.
//
// state  | meaning
// IDLE   | waiting for an operand pair, in_ready high
// MUL    | one shift-add iteration per cycle, WIDTH cycles total
// DONE   | fold product low bits into x, pulse out_valid
module secret_mac #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] x,
    output logic             busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    // Only the low WIDTH product bits ever reach x, and those depend only on
    // the low WIDTH bits of the shifted multiplicand, so the upper half is not kept.
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] prod;

    assign in_ready = (state == S_IDLE);
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            prod      <= '0;
            x         <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (clear) begin
                x <= '0;
            end
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        mcand  <= a;
                        mplier <= b;
                        prod   <= '0;
                        cnt    <= '0;
                        state  <= S_MUL;
                    end
                end
                S_MUL: begin
                    if (mplier[0]) begin
                        prod <= prod + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_ONE;
                    if (cnt == CNT_LAST) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // A coincident clear zeroes x before the product is added.
                    x         <= (clear ? '0 : x) + prod;
                    out_valid <= 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_secret_mac.sv
// Directed self-checking bench for secret_mac: latency, accumulation, wrap,
// back-to-back handshake, clear behaviour and asynchronous reset mid-multiply.
module tb_secret_mac;

    localparam int WIDTH = 32;
    localparam int LAT   = WIDTH + 1;

    logic             clk;
    logic             rst;
    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic [WIDTH-1:0] x;
    logic             busy;

    int n_cmp = 0;
    int n_err = 0;

    secret_mac #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .x        (x),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Counts edges until out_valid is seen; optionally raises clear for the DONE edge.
    task automatic wait_ov(input bit clr_done, output int n);
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (n == WIDTH) chk("done_rdy", {31'd0, in_ready}, 32'd0);
            clear = (clr_done && n == WIDTH);
            if (out_valid) break;
        end
        clear = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_x", x, 32'd0);
        chk("rst_ov", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rdy", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic op(input logic [31:0] av, input logic [31:0] bv, input bit clr_done,
                      input logic [31:0] exp_x, input string tag);
        int n;
        chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
        a = av;
        b = bv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        wait_ov(clr_done, n);
        chk({tag, "_lat"}, n, LAT);
        chk({tag, "_x"}, x, exp_x);
        chk({tag, "_rdy_ov"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        chk({tag, "_ov_off"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        int n;
        int ov_seen;
        rst = 1'b0;
        clear = 1'b0;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        #2;
        do_reset();

        op(32'd5, 32'd7, 1'b0, 32'd35, "p57");
        op(32'd6, 32'd2, 1'b0, 32'd47, "p62");
        op(32'd1, 32'd9, 1'b0, 32'd56, "p19");

        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        chk("clr_idle_x", x, 32'd0);
        chk("clr_idle_ov", {31'd0, out_valid}, 32'd0);

        op(32'd2, 32'd3, 1'b0, 32'd6, "p23");
        op(32'd2, 32'd3, 1'b1, 32'd6, "p23clr");
        op(32'd0, 32'd12345, 1'b0, 32'd6, "zero");

        do_reset();
        op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd1, "wrapff");
        op(32'h8000_0000, 32'd2, 1'b0, 32'd1, "wrap80");

        do_reset();
        a = 32'd3;
        b = 32'd4;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("b2b_mul_rdy", {31'd0, in_ready}, 32'd0);
        wait_ov(1'b0, n);
        chk("b2b1_lat", n, LAT);
        chk("b2b1_x", x, 32'd12);
        chk("b2b1_rdy", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        chk("b2b2_busy", {31'd0, busy}, 32'd1);
        chk("b2b2_ov_off", {31'd0, out_valid}, 32'd0);
        wait_ov(1'b0, n);
        in_valid = 1'b0;
        chk("b2b2_lat", n, LAT);
        chk("b2b2_x", x, 32'd24);
        @(posedge clk);
        #1;

        a = 32'd9;
        b = 32'd9;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_x", x, 32'd0);
        chk("midrst_rdy", {31'd0, in_ready}, 32'd1);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ov_seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) ov_seen++;
        end
        chk("midrst_no_ov", ov_seen, 32'd0);
        chk("midrst_idle", {31'd0, in_ready}, 32'd1);
        op(32'd1, 32'd1, 1'b0, 32'd1, "p11");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
